multiplier_controller_taint: RTL and testbench
==============================================

MULTIPLIER_CONTROLLER_TAINT -- requirements
Module: multiplier_controller_taint

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; the value SHALL be at least 1.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Port: start_t  input  1  taint of start.
REQ-006 Port: multiplierReg  input  WIDTH  multiplier register from the datapath.
REQ-007 Port: multiplierReg_t  input  WIDTH  taint of multiplierReg.
REQ-008 Ports: rsload, rsclear, rsshr, mrld, mdld  output  1 each  datapath controls.
REQ-009 Ports: rsload_t, rsclear_t, rsshr_t, mrld_t, mdld_t  output  1 each  control taints.
REQ-010 Ports: busy, done  output  1 each  busy is high outside IDLE; done is a one-cycle completion pulse.
REQ-011 Ports: busy_t, done_t  output  1 each  taints of busy and done.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, ADD, SHIFT and DONE; all outputs SHALL be registered-state decodes with no combinational path from start.
REQ-013 IDLE SHALL go to LOAD when start=1 and stay in IDLE otherwise.
REQ-014 LOAD SHALL assert mrld, mdld and rsclear for exactly one cycle, clear the bit counter cnt to 0, and go to ADD.
REQ-015 ADD SHALL assert rsload=multiplierReg[cnt] and go to SHIFT; ADD and SHIFT SHALL never assert rsload and rsshr in the same cycle.
REQ-016 SHIFT SHALL assert rsshr, then go to DONE if cnt==WIDTH-1; otherwise it SHALL increment cnt and go to ADD.
REQ-017 DONE SHALL assert done for one cycle and go to IDLE.
REQ-018 Latency SHALL be fixed and independent of data: with start accepted in cycle N, LOAD is at N+1, bit k uses ADD at N+2+2k and SHIFT at N+3+2k, and DONE is at N+2+2·WIDTH.
REQ-019 start SHALL be ignored while busy; a new start SHALL be accepted in the IDLE cycle that follows DONE.
REQ-020 cnt SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap; WIDTH=1 SHALL give exactly one ADD/SHIFT pair.
REQ-021 The state-taint flag st_t SHALL load start_t on every IDLE cycle and hold its value in all other states.
REQ-022 The taint outputs rsclear_t, rsshr_t, mrld_t, mdld_t, busy_t and done_t SHALL each equal st_t.
REQ-023 rsload_t SHALL equal st_t | (state==ADD & multiplierReg_t[cnt]).
REQ-024 Tainted multiplier bits SHALL NOT taint state, cnt, done or busy, because control flow does not depend on data.

Reset
REQ-025 With rst=1 at a clock edge, in any state, the next cycle SHALL have state=IDLE, cnt=0, st_t=0, and all control, done, busy and taint outputs at 0.
REQ-026 rst SHALL take priority over start on the same edge, and a mid-operation reset SHALL produce no done pulse.

Configuration
REQ-027 With macro MULT_CTRL_TAINT_EN defined, the taint logic SHALL be as specified in REQ-021 to REQ-024.
REQ-028 Without MULT_CTRL_TAINT_EN, st_t SHALL be removed, all *_t outputs SHALL be tied to 0, the *_t inputs SHALL be unused, and the functional behaviour SHALL be identical.

Structure
REQ-029 Shared package mult_pkg SHALL hold the FSM state enum (3-bit encoding) and a function returning the cnt width for a given WIDTH.
REQ-030 The block SHALL be a single module with no sub-module; the counter and taint flag SHALL be inline.

Verification
REQ-031 WIDTH=4, multiplierReg=4'b1011, start at cycle 0 -> LOAD at cycle 1; rsload=1 at cycles 2, 4 and 8 and 0 at cycle 6; rsshr at cycles 3, 5, 7 and 9; done at cycle 10; busy high for cycles 1-10.
REQ-032 start_t=1 with start=1 in IDLE -> every *_t output is 1 from cycle 1 to cycle 10; the next IDLE cycle with start_t=0 -> all taints 0.
REQ-033 start_t=0, multiplierReg_t=4'b0100 -> rsload_t=1 only at cycle 6 (the ADD for bit 2), and all other taints stay 0.
REQ-034 rst asserted at cycle 5 mid-operation -> IDLE with all outputs 0 at cycle 6 and no done pulse; a start at cycle 7 -> a clean run with done at cycle 17.
REQ-035 start held high continuously -> done at cycles 10 and 21, and start pulses during busy do not change timing.
REQ-036 WIDTH=1, multiplierReg=1 -> LOAD at cycle 1, ADD with rsload=1 at cycle 2, SHIFT at cycle 3, done at cycle 4.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the taint-tracking multiplier controller:
// FSM state encoding and the bit-counter width helper.
package mult_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/multiplier_controller_taint.sv
// Shift-add multiplier controller with fixed latency and optional taint
// tracking (MULT_CTRL_TAINT_EN). Ports:
//   clk, rst (sync, active-high), start/start_t, multiplierReg/_t [WIDTH]
//   rsload, rsclear, rsshr, mrld, mdld, busy, done and their *_t taints.
module multiplier_controller_taint
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             rsload,
    output logic             rsclear,
    output logic             rsshr,
    output logic             mrld,
    output logic             mdld,
    output logic             busy,
    output logic             done,
    output logic             rsload_t,
    output logic             rsclear_t,
    output logic             rsshr_t,
    output logic             mrld_t,
    output logic             mdld_t,
    output logic             busy_t,
    output logic             done_t
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ADD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Mux by comparison so the index never exceeds the operand range.
    always_comb begin
        bit_sel = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) bit_sel = multiplierReg[i];
        end
    end

    assign rsload  = (state_q == S_ADD) & bit_sel;
    assign rsshr   = (state_q == S_SHIFT);
    assign rsclear = (state_q == S_LOAD);
    assign mrld    = (state_q == S_LOAD);
    assign mdld    = (state_q == S_LOAD);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

`ifdef MULT_CTRL_TAINT_EN
    logic st_t_q;
    logic bit_t;

    // Control flow is data-independent, so only start_t feeds the state taint.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_t_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            st_t_q <= start_t;
        end
    end

    always_comb begin
        bit_t = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) bit_t = multiplierReg_t[i];
        end
    end

    assign rsload_t  = st_t_q | ((state_q == S_ADD) & bit_t);
    assign rsclear_t = st_t_q;
    assign rsshr_t   = st_t_q;
    assign mrld_t    = st_t_q;
    assign mdld_t    = st_t_q;
    assign busy_t    = st_t_q;
    assign done_t    = st_t_q;
`else
    logic unused_taint;
    assign unused_taint = ^{start_t, multiplierReg_t};

    assign rsload_t  = 1'b0;
    assign rsclear_t = 1'b0;
    assign rsshr_t   = 1'b0;
    assign mrld_t    = 1'b0;
    assign mdld_t    = 1'b0;
    assign busy_t    = 1'b0;
    assign done_t    = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_controller_taint.sv
// Self-checking bench for multiplier_controller_taint (WIDTH=4 and WIDTH=1):
// directed vector table, reset/back-to-back sequences and random stimulus.
module tb_multiplier_controller_taint;

`ifdef MULT_CTRL_TAINT_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, start_t;
    logic [3:0] mr, mrt;
    wire  [13:0] o4, o1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dq[$];
    int d1q[$];

    int  ph4, ph1;
    bit  stt4, stt1;

    always #5 clk = ~clk;

    multiplier_controller_taint #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplierReg(mr), .multiplierReg_t(mrt),
        .rsload(o4[13]), .rsclear(o4[12]), .rsshr(o4[11]),
        .mrld(o4[10]), .mdld(o4[9]), .busy(o4[8]), .done(o4[7]),
        .rsload_t(o4[6]), .rsclear_t(o4[5]), .rsshr_t(o4[4]),
        .mrld_t(o4[3]), .mdld_t(o4[2]), .busy_t(o4[1]), .done_t(o4[0])
    );

    multiplier_controller_taint #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplierReg(mr[0:0]), .multiplierReg_t(mrt[0:0]),
        .rsload(o1[13]), .rsclear(o1[12]), .rsshr(o1[11]),
        .mrld(o1[10]), .mdld(o1[9]), .busy(o1[8]), .done(o1[7]),
        .rsload_t(o1[6]), .rsclear_t(o1[5]), .rsshr_t(o1[4]),
        .mrld_t(o1[3]), .mdld_t(o1[2]), .busy_t(o1[1]), .done_t(o1[0])
    );

    typedef struct {
        logic       r, s, st;
        logic [3:0] m, mt;
        logic [6:0] e;
        logic       et, erl;
    } vec_t;

    vec_t tv[$];

    // ph = cycles since start was accepted (0 when idle).
    function automatic logic [13:0] mexp(input int w, input int ph,
                                         input bit stt,
                                         input logic [3:0] m,
                                         input logic [3:0] mt);
        logic add, sh, ml, bz, dn, ld, tb, rlt;
        int   k;
        bz  = (ph != 0);
        ml  = (ph == 1);
        add = (ph >= 2) && (ph <= 2 * w) && (ph % 2 == 0);
        sh  = (ph >= 3) && (ph <= 2 * w + 1) && (ph % 2 == 1);
        dn  = (ph == 2 * w + 2);
        k   = add ? (ph - 2) / 2 : 0;
        ld  = add & m[k];
        tb  = TE & stt;
        rlt = tb | (TE & add & mt[k]);
        return {ld, ml, sh, ml, ml, bz, dn, rlt, tb, tb, tb, tb, tb, tb};
    endfunction

    function automatic void mstep(input int w, inout int ph, inout bit stt);
        if (rst) begin
            ph  = 0;
            stt = 1'b0;
        end else if (ph == 0) begin
            stt = start_t;
            ph  = start ? 1 : 0;
        end else begin
            ph = (ph == 2 * w + 2) ? 0 : ph + 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [13:0] a,
                       input logic [13:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, a, e);
        end
    endtask

    task automatic chk_i(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic st,
                         input logic [3:0] m, input logic [3:0] mt);
        logic [3:0] m1, mt1;
        rst = r; start = s; start_t = st; mr = m; mrt = mt;
        #1;
        m1  = {3'b000, m[0]};
        mt1 = {3'b000, mt[0]};
        chk("model_w4", o4, mexp(4, ph4, stt4, m, mt));
        chk("model_w1", o1, mexp(1, ph1, stt1, m1, mt1));
        if (o4[7]) dq.push_back(cyc);
        if (o1[7]) d1q.push_back(cyc);
        @(posedge clk);
        mstep(4, ph4, stt4);
        mstep(1, ph1, stt1);
        cyc++;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic s, input logic st,
                                input logic [3:0] m, input logic [3:0] mt,
                                input logic [6:0] e, input logic et,
                                input logic erl);
        vec_t v;
        v.r = 1'b0; v.s = s; v.st = st; v.m = m; v.mt = mt;
        v.e = e; v.et = et; v.erl = erl;
        return v;
    endfunction

    localparam logic [6:0] IDL = 7'b0000000;
    localparam logic [6:0] LDS = 7'b0101110;
    localparam logic [6:0] AD1 = 7'b1000010;
    localparam logic [6:0] AD0 = 7'b0000010;
    localparam logic [6:0] SHS = 7'b0010010;
    localparam logic [6:0] DNS = 7'b0000011;

    initial begin
        logic [6:0] got7;
        int first;
        rst = 1'b1; start = 1'b0; start_t = 1'b0; mr = '0; mrt = '0;
        ph4 = 0; ph1 = 0; stt4 = 1'b0; stt1 = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_w4", o4, 14'd0);
        chk("reset_w1", o1, 14'd0);

        tv.push_back(mk(1, 1, 4'b1011, 4'b0000, IDL, 0, 0));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, LDS, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, AD1, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, SHS, 1, 1));
        tv.push_back(mk(1, 0, 4'b1011, 4'b0000, AD1, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, SHS, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, AD0, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, SHS, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, AD1, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, SHS, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, DNS, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, IDL, 1, 1));
        tv.push_back(mk(0, 0, 4'b1011, 4'b0000, IDL, 0, 0));
        tv.push_back(mk(1, 0, 4'b0110, 4'b0100, IDL, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, LDS, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, AD0, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, SHS, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, AD1, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, SHS, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, AD1, 0, 1));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, SHS, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, AD0, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, SHS, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, DNS, 0, 0));
        tv.push_back(mk(0, 0, 4'b0110, 4'b0100, IDL, 0, 0));

        cyc = 0;
        dq.delete();
        d1q.delete();
        foreach (tv[i]) begin
            rst = tv[i].r; start = tv[i].s; start_t = tv[i].st;
            mr = tv[i].m; mrt = tv[i].mt;
            #1;
            got7 = o4[13:7];
            chk("vec_ctrl", {7'd0, got7}, {7'd0, tv[i].e});
            chk("vec_taint", {7'd0, o4[6:0]},
                {7'd0, tv[i].erl & TE, {6{tv[i].et & TE}}});
            cycle(tv[i].r, tv[i].s, tv[i].st, tv[i].m, tv[i].mt);
        end
        first = (d1q.size() > 0) ? d1q[0] : -1;
        chk_i("w1_done_cycle", first, 4);

        cycle(1, 0, 0, 4'b0000, 4'b0000);
        cyc = 0;
        dq.delete();
        for (int c = 0; c < 20; c++) begin
            cycle(c == 5, (c == 0) || (c == 7), 0, 4'b1101, 4'b0000);
        end
        chk_i("rst_mid_done_count", dq.size(), 1);
        first = (dq.size() > 0) ? dq[0] : -1;
        chk_i("rst_mid_done_cycle", first, 17);

        cycle(1, 0, 0, 4'b0000, 4'b0000);
        cyc = 0;
        dq.delete();
        for (int c = 0; c < 23; c++) begin
            cycle(0, 1, 0, 4'($urandom), 4'b0000);
        end
        chk_i("b2b_done_count", dq.size(), 2);
        first = (dq.size() > 0) ? dq[0] : -1;
        chk_i("b2b_done_first", first, 10);
        first = (dq.size() > 1) ? dq[1] : -1;
        chk_i("b2b_done_second", first, 21);

        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                  1'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
